// File: rtl/pow2_unit.sv
// pow2_unit: 3-stage pipelined signed Q5.26 result = +/-2^exponent with saturation/flush flags.
// Optional quadratic mantissa approximation enabled by defining POW2_QUAD_EN.
module pow2_unit #(
  parameter int Q = 26,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [W-1:0] exponent,
  input  logic         result_sign,
  input  logic         div_by_zero,
  output logic         valid_out,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         dbz_out
);
  localparam int IW = W - Q;
  localparam logic signed [IW-1:0] OVF_I = IW'(W - 1 - Q);
  localparam logic signed [IW-1:0] UNF_I = IW'(-(Q + 1));
  logic s1_v, s1_sign, s1_dbz, s2_v, s2_sign, s2_dbz;
  logic signed [IW-1:0] s1_i, s2_i;
  logic [Q-1:0] s1_f;
  logic [Q:0] m_c, s2_m;
  logic [IW-1:0] neg;
  logic [W-1:0] mag, res;
  logic ovf, unf;
`ifdef POW2_QUAD_EN
  logic [Q-1:0] s1_t, t_c;
  // t = 21/32 + 11f/32, then m = 1 + f*t, both truncated
  assign t_c = Q'(21 << (Q - 5)) + Q'(((Q+4)'(exponent[Q-1:0]) * (Q+4)'(11)) >> 5);
  assign m_c = {1'b1, Q'(((2*Q)'(s1_f) * (2*Q)'(s1_t)) >> Q)};
`else
  assign m_c = {1'b1, s1_f};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_sign <= 1'b0;
      s1_dbz <= 1'b0;
      s1_i <= '0;
      s1_f <= '0;
`ifdef POW2_QUAD_EN
      s1_t <= '0;
`endif
    end else begin
      s1_v <= valid_in;
      s1_sign <= result_sign;
      s1_dbz <= div_by_zero;
      s1_i <= exponent[W-1:Q];
      s1_f <= exponent[Q-1:0];
`ifdef POW2_QUAD_EN
      s1_t <= t_c;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
      s2_sign <= 1'b0;
      s2_dbz <= 1'b0;
      s2_i <= '0;
      s2_m <= '0;
    end else begin
      s2_v <= s1_v;
      s2_sign <= s1_sign;
      s2_dbz <= s1_dbz;
      s2_i <= s1_i;
      s2_m <= m_c;
    end
  end
  assign neg = -s2_i;
  always_comb begin
    ovf = s2_dbz || (s2_i >= OVF_I);
    unf = !s2_dbz && (s2_i <= UNF_I);
    mag = ovf ? {1'b0, {(W-1){1'b1}}} :
          unf ? '0 :
          s2_i[IW-1] ? W'(s2_m) >> neg : W'(s2_m) << s2_i;
    res = s2_sign ? -mag : mag;
  end
  // outputs only move on a qualified sample and hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      dbz_out <= 1'b0;
    end else begin
      valid_out <= s2_v;
      if (s2_v) begin
        result <= res;
        overflow <= ovf;
        underflow <= unf;
        dbz_out <= s2_dbz;
      end
    end
  end
endmodule

// File: tb/tb_pow2_unit.sv
// tb_pow2_unit: directed self-checking bench for pow2_unit (default or POW2_QUAD_EN build).
module tb_pow2_unit;
  logic clk = 1'b0;
  logic rst, valid_in, result_sign, div_by_zero;
  logic [31:0] exponent;
  logic valid_out, overflow, underflow, dbz_out;
  logic [31:0] result;
  int pass_cnt = 0;
  int total = 0;

  pow2_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .exponent(exponent),
    .result_sign(result_sign), .div_by_zero(div_by_zero), .valid_out(valid_out),
    .result(result), .overflow(overflow), .underflow(underflow), .dbz_out(dbz_out)
  );

  always #5 clk = ~clk;

`ifdef POW2_QUAD_EN
  localparam logic [31:0] HALF = 32'h05A8_0000;
  localparam logic [31:0] MAXV = 32'h7FFF_FFE0;
  localparam logic [31:0] FRAC = 32'h012F_8000;
`else
  localparam logic [31:0] HALF = 32'h0600_0000;
  localparam logic [31:0] MAXV = 32'h7FFF_FFF0;
  localparam logic [31:0] FRAC = 32'h0140_0000;
`endif

  typedef struct packed {
    logic [31:0] e;
    logic s;
    logic z;
    logic [31:0] r;
    logic o;
    logic u;
  } vec_t;

  // -28.0 in Q5.26 is 0x90000000; 0xF9000000 is -1.75 (I=-2, f=0.25)
  vec_t vecs [16] = '{
    '{32'h0400_0000, 1'b0, 1'b0, 32'h0800_0000, 1'b0, 1'b0},
    '{32'h0200_0000, 1'b0, 1'b0, HALF,          1'b0, 1'b0},
    '{32'hFC00_0000, 1'b0, 1'b0, 32'h0200_0000, 1'b0, 1'b0},
    '{32'h0800_0000, 1'b1, 1'b0, 32'hF000_0000, 1'b0, 1'b0},
    '{32'h1400_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0},
    '{32'h9000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1},
    '{32'h0000_0000, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 1'b0},
    '{32'h1000_0000, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0},
    '{32'h13FF_FFFF, 1'b0, 1'b0, MAXV,          1'b0, 1'b0},
    '{32'h9800_0000, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0},
    '{32'h9400_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1},
    '{32'hF900_0000, 1'b0, 1'b0, FRAC,          1'b0, 1'b0},
    '{32'h1400_0000, 1'b1, 1'b0, 32'h8000_0001, 1'b1, 1'b0},
    '{32'h9000_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0},
    '{32'h0000_0000, 1'b0, 1'b0, 32'h0400_0000, 1'b0, 1'b0},
    '{32'h9000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1}
  };

  task automatic drive(input logic v, input logic [31:0] e, input logic s, input logic z);
    valid_in = v;
    exponent = e;
    result_sign = s;
    div_by_zero = z;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h0400_0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if ({valid_out, result, overflow, underflow, dbz_out} !== 36'd0)
      $display("FAIL reset_state: got v=%b r=%h o=%b u=%b d=%b, want all 0",
               valid_out, result, overflow, underflow, dbz_out);
    else pass_cnt++;
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b0) $display("FAIL reset_ignored_input: cycle %0d valid_out=%b, want 0", n, valid_out);
      else pass_cnt++;
    end
  endtask

  task automatic test_vectors();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, vecs[k].e, vecs[k].s, vecs[k].z);
      @(negedge clk);
      drive(1'b0, 32'h1234_5678, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (valid_out !== 1'b0) $display("FAIL vec%0d_early: valid_out=%b after 2 edges, want 0", k, valid_out);
      else pass_cnt++;
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1) $display("FAIL vec%0d_valid: valid_out=%b after 3 edges, want 1", k, valid_out);
      else pass_cnt++;
      total++;
      if (result !== vecs[k].r) $display("FAIL vec%0d_result: got %h, want %h", k, result, vecs[k].r);
      else pass_cnt++;
      total++;
      if ({overflow, underflow, dbz_out} !== {vecs[k].o, vecs[k].u, vecs[k].z})
        $display("FAIL vec%0d_flags: got o/u/d=%b%b%b, want %b%b%b", k, overflow, underflow, dbz_out,
                 vecs[k].o, vecs[k].u, vecs[k].z);
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 32'h0800_0000, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h1400_0000, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    total++;
    if ({valid_out, result, overflow, underflow, dbz_out} !== {1'b0, 32'hF000_0000, 3'b000})
      $display("FAIL hold: got v=%b r=%h o=%b u=%b d=%b, want v=0 r=f0000000 flags 0",
               valid_out, result, overflow, underflow, dbz_out);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [4] = '{32'h0800_0000, 32'h0200_0000, 32'h4000_0000, 32'hFE00_0000};
    logic [31:0] exp_e [4] = '{32'h0400_0000, 32'hFC00_0000, 32'h1000_0000, 32'hFC00_0000};
    logic exp_s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int n = 0; n < 8; n++) begin
      total++;
      if (valid_out !== (n >= 3 && n <= 6))
        $display("FAIL b2b_valid: cycle %0d valid_out=%b, want %b", n, valid_out, (n >= 3 && n <= 6));
      else pass_cnt++;
      if (n >= 3 && n <= 6) begin
        total++;
        if (result !== exp_r[n-3]) $display("FAIL b2b_result%0d: got %h, want %h", n - 3, result, exp_r[n-3]);
        else pass_cnt++;
      end
      if (n < 4) drive(1'b1, exp_e[n], exp_s[n], 1'b0);
      else drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_flush();
    drive(1'b1, 32'h0400_0000, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h0800_0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h1000_0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    total++;
    if ({valid_out, result, overflow, underflow, dbz_out} !== 36'd0)
      $display("FAIL flush_state: got v=%b r=%h o=%b u=%b d=%b, want all 0",
               valid_out, result, overflow, underflow, dbz_out);
    else pass_cnt++;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b0) $display("FAIL flush_no_output: cycle %0d valid_out=%b, want 0", n, valid_out);
      else pass_cnt++;
    end
    drive(1'b1, 32'h0800_0000, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0) $display("FAIL post_reset_early: valid_out=%b, want 0", valid_out);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({valid_out, result} !== {1'b1, 32'h1000_0000})
      $display("FAIL post_reset_first: got v=%b r=%h, want v=1 r=10000000", valid_out, result);
    else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
